// File: rtl/fam_share_arbiter_pkg.sv
// Shared types for the FAM share arbiter: FPI<->FAM payload structs, arbiter
// FSM states and payload width constants.
package fam_share_arbiter_pkg;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rs3;
        logic [2:0]  rm;
    } f_fam_in_data_s;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  fflags;
    } f_mac_out_s;

    typedef struct packed {
        logic           v;
        f_fam_in_data_s data;
    } f_fam_in_s;

    typedef struct packed {
        logic       v;
        f_mac_out_s data;
    } f_fam_out_s;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } fam_arb_state_e;

    localparam int unsigned RV32_mac_input_width_gp  = $bits(f_fam_in_data_s);
    localparam int unsigned RV32_mac_output_width_gp = $bits(f_mac_out_s);

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fam_share_arbiter_if.sv
// FPI request/response and FAM issue/return signals of the share arbiter.
// slave = arbiter side, master = FPIs plus FAM side.
interface fam_share_arbiter_if
    import fam_share_arbiter_pkg::*;
#(
    parameter int unsigned num_req_p   = 2,
    parameter int unsigned in_width_p  = RV32_mac_input_width_gp,
    parameter int unsigned out_width_p = RV32_mac_output_width_gp
);
    logic [num_req_p-1:0]            req_v_i;
    logic [num_req_p*in_width_p-1:0] req_data_i;
    logic [num_req_p-1:0]            req_ready_o;
    logic                            fam_v_o;
    logic [in_width_p-1:0]           fam_data_o;
    logic                            fam_ready_i;
    logic                            fam_v_i;
    logic [out_width_p-1:0]          fam_data_i;
    logic                            fam_yumi_o;
    logic [num_req_p-1:0]            resp_v_o;
    logic [out_width_p-1:0]          resp_data_o;
    logic [num_req_p-1:0]            resp_yumi_i;

    modport slave (
        input  req_v_i, req_data_i, fam_ready_i, fam_v_i, fam_data_i, resp_yumi_i,
        output req_ready_o, fam_v_o, fam_data_o, fam_yumi_o, resp_v_o, resp_data_o
    );

    modport master (
        output req_v_i, req_data_i, fam_ready_i, fam_v_i, fam_data_i, resp_yumi_i,
        input  req_ready_o, fam_v_o, fam_data_o, fam_yumi_o, resp_v_o, resp_data_o
    );
endinterface

// File: rtl/fam_share_arbiter_owner_fifo.sv
// In-order owner-tag FIFO: records which FPI issued each in-flight FAM op.
// Simultaneous push and pop while full is legal and leaves the count unchanged.
module fam_owner_fifo
    import fam_share_arbiter_pkg::*;
#(
    parameter int unsigned depth_p = 4,
    parameter int unsigned width_p = 1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             push_i,
    input  logic [width_p-1:0]               data_i,
    input  logic                             pop_i,
    output logic [width_p-1:0]               data_o,
    output logic [$clog2(depth_p+1)-1:0]     count_o,
    output logic                             full_o,
    output logic                             empty_o
);
    localparam int unsigned ptr_w_lp = clog2_min1(depth_p);
    localparam int unsigned cnt_w_lp = $clog2(depth_p + 1);

    logic [width_p-1:0]  mem_q [depth_p];
    logic [ptr_w_lp-1:0] head_q, head_d, tail_q, tail_d;
    logic [cnt_w_lp-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + cnt_w_lp'(push_i) - cnt_w_lp'(pop_i);
        if (pop_i)
            head_d = (head_q == ptr_w_lp'(depth_p - 1)) ? '0 : head_q + 1'b1;
        if (push_i)
            tail_d = (tail_q == ptr_w_lp'(depth_p - 1)) ? '0 : tail_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i)
            mem_q[tail_q] <= data_i;
    end

    assign data_o  = mem_q[head_q];
    assign count_o = count_q;
    assign full_o  = (count_q == cnt_w_lp'(depth_p));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fam_share_arbiter.sv
// Round-robin sharing of one FAM between num_req_p FPIs with in-order result steering.
// Optional per-FPI grant and conflict counters are built when FAM_ARB_STATS_EN is defined.
module fam_share_arbiter
    import fam_share_arbiter_pkg::*;
#(
    parameter int unsigned num_req_p      = 2,
    parameter int unsigned max_inflight_p = 4,
    parameter int unsigned in_width_p     = RV32_mac_input_width_gp,
    parameter int unsigned out_width_p    = RV32_mac_output_width_gp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               drain_i,
    output logic               drained_o,
    fam_share_arbiter_if.slave bus
`ifdef FAM_ARB_STATS_EN
    , output logic [num_req_p*32-1:0] grant_cnt_o
    , output logic [31:0]             conflict_cnt_o
`endif
);
    localparam int unsigned tag_w_lp = clog2_min1(num_req_p);
    localparam int unsigned cnt_w_lp = $clog2(max_inflight_p + 1);

    fam_arb_state_e      state_q, state_d;
    logic [tag_w_lp-1:0] rr_q, rr_d, winner, head_tag;
    logic [cnt_w_lp-1:0] fifo_count;
    logic                found, grant_ok, accept, pop, fifo_full, fifo_empty, resp_any;
    int unsigned         idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            idx = (32'(rr_q) + i) % num_req_p;
            if (!found && bus.req_v_i[tag_w_lp'(idx)]) begin
                winner = tag_w_lp'(idx);
                found  = 1'b1;
            end
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign resp_any = !reset_i && bus.fam_v_i && !fifo_empty;
    assign pop      = |(bus.resp_yumi_i & bus.resp_v_o);
    assign grant_ok = !reset_i && (state_q == RUN) && bus.fam_ready_i && (!fifo_full || pop);
    assign accept   = found && grant_ok;

    always_comb begin
        bus.fam_v_o     = accept;
        bus.req_ready_o = accept ? (num_req_p'(1) << winner) : '0;
        bus.fam_data_o  = accept ? bus.req_data_i[32'(winner)*in_width_p +: in_width_p] : '0;
        bus.resp_v_o    = resp_any ? (num_req_p'(1) << head_tag) : '0;
        bus.resp_data_o = reset_i ? '0 : bus.fam_data_i;
        bus.fam_yumi_o  = pop;
        rr_d            = rr_q;
        if (accept)
            rr_d = (winner == tag_w_lp'(num_req_p - 1)) ? '0 : winner + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        drained_o = 1'b0;
        unique case (state_q)
            RUN:     if (drain_i) state_d = DRAIN;
            DRAIN:   if (!drain_i) state_d = RUN;
                     else if (fifo_count == '0 && !pop) state_d = DRAINED;
            DRAINED: begin
                drained_o = 1'b1;
                if (!drain_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= RUN;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    fam_owner_fifo #(
        .depth_p (max_inflight_p),
        .width_p (tag_w_lp)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (accept),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (head_tag),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    a_no_orphan_result: assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.fam_v_i && fifo_empty));

`ifdef FAM_ARB_STATS_EN
    logic [num_req_p-1:0][31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0]                conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        grant_cnt_d    = grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        for (int unsigned i = 0; i < num_req_p; i++)
            if (accept && 32'(winner) == i && grant_cnt_q[i] != '1)
                grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
        if (grant_ok && $countones(bus.req_v_i) > 1 && conflict_cnt_q != '1)
            conflict_cnt_d = conflict_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt_o    = grant_cnt_q;
    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
